// File: rtl/regfile_pkg.sv
// Shared constants and elaboration-time helpers for the integer register file.
// Address and data types are sized in each module because they depend on per-instance parameters.
package regfile_pkg;

    localparam int ZERO_ADDR = 0;

    // Constant function so that the address width can be derived in a module's parameter list.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one pending flag per register, issue-over-writeback priority,
// per-port busy lookup with writeback bypass, and an "all clear" flag.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int   DEPTH    = 32,
    parameter int   NRD      = 2,
    parameter bit   ZERO_REG = 1'b1,
    localparam int  AW       = clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_valid,
    input  logic [AW-1:0]          issue_addr,
    input  logic                   we,
    input  logic [AW-1:0]          writeaddr,
    input  logic [NRD-1:0][AW-1:0] readaddr,
    output logic [NRD-1:0]         readbusy,
    output logic                   sb_empty
);

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_set;
    logic [DEPTH-1:0] w_clr;
    logic             w_issue_en;

    // With a hard-wired zero register, r0 is never a real producer target.
    assign w_issue_en = issue_valid && !(ZERO_REG && (issue_addr == AW'(ZERO_ADDR)));

    // NOTE: every variable driven here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (w_issue_en) w_set[issue_addr] = 1'b1;
        if (we)         w_clr[writeaddr]  = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            // Set applied after clear: a same-edge issue wins over the retiring writeback.
            r_busy <= (r_busy & ~w_clr) | w_set;
        end
    end

    always_comb begin
        readbusy = '0;
        for (int p = 0; p < NRD; p++) begin
            readbusy[p] = r_busy[readaddr[p]] && !(we && (writeaddr == readaddr[p]));
        end
    end

    assign sb_empty = ~|r_busy;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port integer register file with same-cycle write bypass and an
// integrated busy-bit scoreboard feeding the hazard/stall unit.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int   WIDTH    = 32,
    parameter int   DEPTH    = 32,
    parameter int   NRD      = 2,
    parameter bit   ZERO_REG = 1'b1,
    localparam int  AW       = clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NRD-1:0][AW-1:0]    readaddr,
    output logic [NRD-1:0][WIDTH-1:0] readdata,
    output logic [NRD-1:0]            readbusy,
    input  logic                      issue_valid,
    input  logic [AW-1:0]             issue_addr,
    input  logic                      we,
    input  logic [AW-1:0]             writeaddr,
    input  logic [WIDTH-1:0]          writedata,
    output logic                      sb_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_wr_en;

    assign w_wr_en = we && !(ZERO_REG && (writeaddr == AW'(ZERO_ADDR)));

    // NOTE: storage is a flop array, not a RAM macro, because the whole file must
    // clear asynchronously; RAMs cannot be reset, so do not copy this pattern for them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_wr_en) begin
            r_mem[writeaddr] <= writedata;
        end
    end

    // Priority: hard-wired zero, then writeback bypass, then stored value.
    always_comb begin
        readdata = '0;
        for (int p = 0; p < NRD; p++) begin
            if (ZERO_REG && (readaddr[p] == AW'(ZERO_ADDR)))
                readdata[p] = '0;
            else if (we && (readaddr[p] == writeaddr))
                readdata[p] = writedata;
            else
                readdata[p] = r_mem[readaddr[p]];
        end
    end

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .NRD      (NRD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .we          (we),
        .writeaddr   (writeaddr),
        .readaddr    (readaddr),
        .readbusy    (readbusy),
        .sb_empty    (sb_empty)
    );

endmodule
